spi1_target: RTL and testbench
==============================

Name: spi1_target

Overview:
- SPI mode-0 target that decodes the host's SPI1 memory-access command stream into single-beat bus transactions with a valid/ready handshake.
- Sits between the MCU-facing SPI1 pins and the system bus arbiter.
- Keeps a 17-bit address pointer that auto-increments after each access.
- Returns read data to the host MSB-first during the first byte of the following SPI transaction.

Parameters:
- CLK_MHZ, 64: system clock frequency. Informational; used only by assertions.
- SCK_MAX_MHZ, 16: maximum supported SCK. SCK must be no faster than CLK_MHZ/4, because SCK is oversampled in the clk_i domain.

Ports:
- clk_i  in  1  system clock; the only clock.
- reset_i  in  1  synchronous, active-high reset.
- spi_sck_i  in  1  SPI clock from host (asynchronous).
- spi_cs_ni  in  1  SPI chip select, active low (asynchronous).
- spi_pico_i  in  1  host-to-target serial data (asynchronous).
- spi_poci_o  out  1  target-to-host serial data.
- addr_o  out  17  bus address.
- data_o  out  8  bus write data.
- rw_no  out  1  1 = read, 0 = write.
- valid_o  out  1  bus request pending.
- ready_i  in  1  bus completion strobe.
- data_i  in  8  bus read data, sampled when valid_o && ready_i.

Behaviour:
- Synchronisation and sampling:
  - spi_sck_i, spi_cs_ni and spi_pico_i each pass through a 2-FF synchroniser.
  - A one-cycle-delayed copy of each gives rise/fall detection.
  - pico is sampled on the SCK rise; poci changes on the SCK fall.
  - Bytes are MSB first. A 3-bit counter counts bits; byte_done pulses on the 8th rise.
- CS handling:
  - CS falling edge: bit counter cleared, rx FSM forced to CMD, tx shift register loaded from rd_buf.
  - CS rising edge: partial byte discarded; rx FSM returns to CMD. A command already complete and issued is unaffected.
- Command byte layout:
  - bit7 = rw_n.
  - bit6 = set_addr.
  - bits5:1 ignored.
  - bit0 = addr[16], used only when set_addr=1.
- rx FSM states: CMD, DATA, ADDR_HI, ADDR_LO, DONE. Transitions on byte_done:
  - CMD: latch rw_n and set_addr; latch cmd[0] as A16 if set_addr.
    - write (rw_n=0) -> DATA.
    - read with set_addr=1 -> ADDR_HI.
    - read with set_addr=0 -> issue, then DONE.
  - DATA: latch wdata. set_addr=1 -> ADDR_HI; otherwise issue, then DONE.
  - ADDR_HI: latch A15:8 -> ADDR_LO.
  - ADDR_LO: latch A7:0; load the pointer with {A16, A15:8, A7:0}; issue, then DONE.
  - DONE: further bytes in the same CS frame are ignored.
- Wire byte orders:
  - write with address: cmd, data, ahi, alo.
  - read with address: cmd, ahi, alo.
  - read next: cmd.
  - write next: cmd, data.
- Issue:
  - valid_o rises the cycle after the issuing byte_done.
  - Latency is at most 4 clk from the synchronised 8th SCK rise at the pin.
  - addr_o = pointer; rw_no = rw_n; data_o = wdata.
- Bus FSM:
  - IDLE -> PEND on issue.
  - In PEND, valid_o, addr_o, data_o and rw_no are held stable until a cycle with ready_i=1.
  - On that cycle: valid_o drops the next cycle; on reads data_i is captured into rd_buf; the pointer increments.
  - Pointer increment is 17-bit with wrap: 1FFFF -> 00000.
  - ready_i while IDLE is ignored.
- Overrun: an issue while PEND (host did not wait) is dropped and sets a sticky overrun flag, cleared only by reset.
- poci:
  - Driven 0 while CS is high.
  - After CS falls: the tx shift MSB is presented; it shifts left on each SCK fall, filling with 0.
  - Bytes after the first shift out 0.
  - First byte = rd_buf = the last completed read.
- Reset values (synchronous, all state):
  - valid_o=0, rw_no=1, addr_o=0, data_o=0, spi_poci_o=0.
  - rd_buf=0, pointer=0, overrun=0.
  - rx FSM = CMD, bus FSM = IDLE.
  - Reset mid-frame or mid-PEND abandons the transaction; the bus sees valid_o drop the next cycle.
  - SPI activity is ignored until the first CS falling edge after reset.

Test Plan:
- Write with address:
  - Stimulus: frame 40 5A E8 0F at 16 MHz SCK.
  - Required: one request with addr_o=0E80F, data_o=5A, rw_no=0; valid_o held through 3 stall cycles until ready_i; pointer becomes 0E810.
- Read then read-next:
  - Stimulus: read frame C1 23 45, bus returns AB; then frame 80 (read next), bus returns CD; then frame 80 again.
  - Required: first request addr 12345 rw_no=1; poci during the second frame's first byte = AB; second request addr 12346; poci during the third frame = CD.
- Wrap:
  - Stimulus: write with address 1FFFF, data 11; then write-next frame 00 22.
  - Required: second request addr_o=00000.
- Aborted frame:
  - Stimulus: frame C0 12 with CS raised after 4 bits of the 3rd byte; then frame 80.
  - Required: no request from the aborted frame; the next request uses the previous pointer.
- Overrun and reset:
  - Stimulus: issue a read with ready_i held low, send frame 80 again; then pulse reset_i during PEND.
  - Required: no second request and overrun=1; after reset valid_o=0, poci=0 and pointer=0.

Source files
------------

// File: rtl/spi1_target.sv
// SPI mode-0 target that turns SPI1 command frames into single-beat bus requests.
// SCK, CS and PICO are oversampled in the clk_i domain; SCK must stay at or below CLK_MHZ/4.
module spi1_target #(
  parameter int CLK_MHZ     = 64,
  parameter int SCK_MAX_MHZ = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        spi_sck_i,
  input  logic        spi_cs_ni,
  input  logic        spi_pico_i,
  output logic        spi_poci_o,
  output logic [16:0] addr_o,
  output logic [7:0]  data_o,
  output logic        rw_no,
  output logic        valid_o,
  input  logic        ready_i,
  input  logic [7:0]  data_i
);

  localparam int MIN_SCK_HALF_CLKS = CLK_MHZ / (2 * SCK_MAX_MHZ);

  typedef enum logic [2:0] {RX_CMD, RX_DATA, RX_ADDR_HI, RX_ADDR_LO, RX_DONE} rx_state_t;
  typedef enum logic {BUS_IDLE, BUS_PEND} bus_state_t;

  logic [1:0] sck_sync, cs_sync, pico_sync;
  logic       sck_d, cs_d, sck_edge_d;
  logic       sck_rise, sck_fall, cs_fall, cs_rise, pico;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sck_sync   <= '0;
      cs_sync    <= '0;  // low at reset: a frame in flight at release never looks like a new CS fall
      pico_sync  <= '0;
      sck_d      <= 1'b0;
      cs_d       <= 1'b0;
      sck_edge_d <= 1'b0;
    end else begin
      sck_sync   <= {sck_sync[0], spi_sck_i};
      cs_sync    <= {cs_sync[0], spi_cs_ni};
      pico_sync  <= {pico_sync[0], spi_pico_i};
      sck_d      <= sck_sync[1];
      cs_d       <= cs_sync[1];
      sck_edge_d <= sck_rise | sck_fall;
      if (MIN_SCK_HALF_CLKS >= 2) assert (!((sck_rise || sck_fall) && sck_edge_d));
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_d;
  assign sck_fall = ~sck_sync[1] & sck_d;
  assign cs_fall  = ~cs_sync[1] & cs_d;
  assign cs_rise  = cs_sync[1] & ~cs_d;
  assign pico     = pico_sync[1];

  logic       in_frame;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] rx_byte, tx_shift;
  logic       byte_done;

  assign rx_byte   = {rx_shift, pico};
  assign byte_done = in_frame & sck_rise & (bit_cnt == 3'd7);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      in_frame <= 1'b0;
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else if (cs_fall) begin
      in_frame <= 1'b1;
      bit_cnt  <= '0;
    end else if (cs_rise) begin
      in_frame <= 1'b0;
      bit_cnt  <= '0;
    end else if (in_frame && sck_rise) begin
      bit_cnt  <= bit_cnt + 3'd1;
      rx_shift <= {rx_shift[5:0], pico};
    end
  end

  logic [7:0] rd_buf;

  always_ff @(posedge clk_i) begin
    if (reset_i)                   tx_shift <= '0;
    else if (cs_fall)              tx_shift <= rd_buf;
    else if (in_frame && sck_fall) tx_shift <= {tx_shift[6:0], 1'b0};
  end

  assign spi_poci_o = in_frame & tx_shift[7];

  rx_state_t  rx_state, rx_next;
  logic       issue, lat_cmd, lat_data, lat_ahi, load_ptr;
  logic       rw_n, set_addr, a16;
  logic [7:0] addr_hi, wdata;

  always_ff @(posedge clk_i) begin
    if (reset_i) rx_state <= RX_CMD;
    else         rx_state <= rx_next;
  end

  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    rx_next  = rx_state;
    issue    = 1'b0;
    lat_cmd  = 1'b0;
    lat_data = 1'b0;
    lat_ahi  = 1'b0;
    load_ptr = 1'b0;
    if (cs_fall || cs_rise) begin
      rx_next = RX_CMD;
    end else if (byte_done) begin
      case (rx_state)
        RX_CMD: begin
          lat_cmd = 1'b1;
          if (!rx_byte[7])     rx_next = RX_DATA;
          else if (rx_byte[6]) rx_next = RX_ADDR_HI;
          else begin
            issue   = 1'b1;
            rx_next = RX_DONE;
          end
        end
        RX_DATA: begin
          lat_data = 1'b1;
          if (set_addr) rx_next = RX_ADDR_HI;
          else begin
            issue   = 1'b1;
            rx_next = RX_DONE;
          end
        end
        RX_ADDR_HI: begin
          lat_ahi = 1'b1;
          rx_next = RX_ADDR_LO;
        end
        RX_ADDR_LO: begin
          load_ptr = 1'b1;
          issue    = 1'b1;
          rx_next  = RX_DONE;
        end
        RX_DONE: rx_next = RX_DONE;
        default: rx_next = RX_CMD;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rw_n     <= 1'b1;
      set_addr <= 1'b0;
      a16      <= 1'b0;
      addr_hi  <= '0;
      wdata    <= '0;
    end else begin
      if (lat_cmd) begin
        rw_n     <= rx_byte[7];
        set_addr <= rx_byte[6];
        if (rx_byte[6]) a16 <= rx_byte[0];
      end
      if (lat_data) wdata   <= rx_byte;
      if (lat_ahi)  addr_hi <= rx_byte;
    end
  end

  // The issuing byte itself may carry rw_n or the write data, so bypass the latches.
  logic       issue_rw, accept;
  logic [7:0] issue_data;
  assign issue_rw   = (rx_state == RX_CMD)  ? rx_byte[7] : rw_n;
  assign issue_data = (rx_state == RX_DATA) ? rx_byte    : wdata;

  bus_state_t  bus_state, bus_next;
  logic [16:0] pointer;
  logic        overrun;

  assign accept = issue && (bus_state == BUS_IDLE);

  always_comb begin
    bus_next = bus_state;
    case (bus_state)
      BUS_IDLE: if (accept)  bus_next = BUS_PEND;
      BUS_PEND: if (ready_i) bus_next = BUS_IDLE;
      default:               bus_next = BUS_IDLE;
    endcase
  end

  // Request fields only change on an accepted issue or a completion, so they hold while pending.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bus_state <= BUS_IDLE;
      pointer   <= '0;
      rw_no     <= 1'b1;
      data_o    <= '0;
      rd_buf    <= '0;
      overrun   <= 1'b0;
    end else begin
      bus_state <= bus_next;
      if (accept) begin
        rw_no  <= issue_rw;
        data_o <= issue_data;
        if (load_ptr) pointer <= {a16, addr_hi, rx_byte};
      end else if (bus_state == BUS_PEND && ready_i) begin
        pointer <= pointer + 17'd1;
        if (rw_no) rd_buf <= data_i;
      end
      if (issue && bus_state == BUS_PEND) overrun <= 1'b1;
    end
  end

  assign addr_o  = pointer;
  assign valid_o = (bus_state == BUS_PEND);

endmodule

// File: tb/tb_spi1_target.sv
// Bench for spi1_target: directed SPI1 frames plus random frames, checked against a
// frame-level model of the pointer, read buffer and overrun flag.
`timescale 1ns/1ps
module tb_spi1_target;

  localparam int SCK_HALF = 32;

  logic        clk, reset_i;
  logic        spi_sck_i, spi_cs_ni, spi_pico_i, spi_poci_o;
  logic [16:0] addr_o;
  logic [7:0]  data_o, data_i;
  logic        rw_no, valid_o, ready_i;

  spi1_target dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .spi_sck_i  (spi_sck_i),
    .spi_cs_ni  (spi_cs_ni),
    .spi_pico_i (spi_pico_i),
    .spi_poci_o (spi_poci_o),
    .addr_o     (addr_o),
    .data_o     (data_o),
    .rw_no      (rw_no),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .data_i     (data_i)
  );

  initial begin
    clk = 1'b0;
    forever #8 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state, one step per SPI frame.
  logic [16:0] m_ptr;
  logic [7:0]  m_rd_buf;
  bit          m_pend, m_overrun;

  // Bus responder.
  bit         resp_en;
  int         resp_stall, stall_cnt;
  logic [7:0] resp_data;

  initial begin
    ready_i   = 1'b0;
    data_i    = '0;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      ready_i = 1'b0;
      if (valid_o && resp_en && !reset_i) begin
        if (stall_cnt >= resp_stall) begin
          ready_i   = 1'b1;
          data_i    = resp_data;
          stall_cnt = 0;
        end else stall_cnt++;
      end else stall_cnt = 0;
    end
  end

  // Request monitor: logs each request and whether its fields moved while valid_o was high.
  typedef struct packed {
    logic [16:0] addr;
    logic [7:0]  data;
    logic        rw;
  } req_t;

  req_t req_q[$];
  req_t mon_cur;
  int   mon_hold;
  bit   mon_changed;
  logic mon_vprev;

  initial begin
    mon_vprev   = 1'b0;
    mon_hold    = 0;
    mon_changed = 0;
    forever begin
      @(negedge clk);
      if (valid_o && !mon_vprev) begin
        mon_cur = {addr_o, data_o, rw_no};
        req_q.push_back(mon_cur);
        mon_hold    = 1;
        mon_changed = 0;
      end else if (valid_o) begin
        mon_hold++;
        if ({addr_o, data_o, rw_no} !== mon_cur) mon_changed = 1;
      end
      mon_vprev = valid_o;
    end
  end

  task automatic spi_frame(input logic [31:0] bytes, input int nbytes, input int extra_bits,
                           output logic [7:0] first_rx);
    first_rx = '0;
    @(negedge clk);
    #3;
    spi_cs_ni = 1'b0;
    #(2 * SCK_HALF);
    for (int i = 0; i < nbytes + ((extra_bits > 0) ? 1 : 0); i++) begin
      for (int j = 7; j >= 0; j--) begin
        if (i == nbytes && (7 - j) >= extra_bits) break;
        spi_pico_i = bytes[24 - 8 * i + j];
        #(SCK_HALF);
        spi_sck_i = 1'b1;
        #(SCK_HALF - 1);
        if (i == 0) first_rx[j] = spi_poci_o;
        #1;
        spi_sck_i = 1'b0;
      end
    end
    #(SCK_HALF);
    spi_cs_ni  = 1'b1;
    spi_pico_i = 1'b0;
    #(4 * SCK_HALF);
  endtask

  task automatic wait_req(output req_t r, output bit got);
    got = 0;
    r   = '0;
    for (int k = 0; k < 100; k++) begin
      if (req_q.size() > 0) begin
        r   = req_q.pop_front();
        got = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output bit got);
    got = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!valid_o) begin
        got = 1;
        break;
      end
    end
  endtask

  // Send one frame and check poci, the resulting request (or its absence) and the pointer.
  task automatic do_frame(input string tag, input logic [31:0] bytes, input int nbytes,
                          input int extra_bits, input logic [7:0] rdata, input int stall);
    logic [7:0]  cmd, b1, b2, b3, rx;
    logic [16:0] e_addr;
    int          need;
    req_t        r;
    bit          got;
    cmd = bytes[31:24];
    b1  = bytes[23:16];
    b2  = bytes[15:8];
    b3  = bytes[7:0];
    resp_data  = rdata;
    resp_stall = stall;
    need = cmd[7] ? (cmd[6] ? 3 : 1) : (cmd[6] ? 4 : 2);
    spi_frame(bytes, nbytes, extra_bits, rx);
    if (nbytes > 0) check({tag, " poci"}, 32'(rx), 32'(m_rd_buf));
    if (nbytes < need) begin
      repeat (8) @(negedge clk);
      check({tag, " no req"}, 32'(req_q.size()), 32'd0);
      return;
    end
    if (!cmd[6])    e_addr = m_ptr;
    else if (cmd[7]) e_addr = {cmd[0], b1, b2};
    else             e_addr = {cmd[0], b2, b3};
    if (m_pend) begin
      m_overrun = 1;
      repeat (8) @(negedge clk);
      check({tag, " dropped"}, 32'(req_q.size()), 32'd0);
      check({tag, " overrun"}, 32'(dut.overrun), 32'(m_overrun));
      return;
    end
    wait_req(r, got);
    check({tag, " req seen"}, 32'(got), 32'd1);
    if (!got) return;
    check({tag, " addr"}, 32'(r.addr), 32'(e_addr));
    check({tag, " rw"}, 32'(r.rw), 32'(cmd[7]));
    if (!cmd[7]) check({tag, " data"}, 32'(r.data), 32'(b1));
    if (!resp_en) begin
      m_pend = 1;
      m_ptr  = e_addr;
      return;
    end
    wait_idle(got);
    check({tag, " completed"}, 32'(got), 32'd1);
    check({tag, " held"}, 32'(mon_changed), 32'd0);
    check({tag, " hold len"}, 32'(mon_hold), 32'(stall + 1));
    m_ptr = 17'((32'(e_addr) + 1) % 32'h20000);
    if (cmd[7]) m_rd_buf = rdata;
    check({tag, " pointer"}, 32'(dut.pointer), 32'(m_ptr));
  endtask

  logic [31:0] rnd, fill;
  logic [16:0] raddr;
  int          kind, nb, need_r, extra;

  initial begin
    reset_i    = 1'b1;
    spi_cs_ni  = 1'b1;
    spi_sck_i  = 1'b0;
    spi_pico_i = 1'b0;
    resp_en    = 1;
    resp_stall = 0;
    resp_data  = '0;
    m_ptr      = '0;
    m_rd_buf   = '0;
    m_pend     = 0;
    m_overrun  = 0;
    repeat (4) @(negedge clk);
    reset_i = 1'b0;
    repeat (2) @(negedge clk);

    check("rst valid", 32'(valid_o), 32'd0);
    check("rst rw", 32'(rw_no), 32'd1);
    check("rst addr", 32'(addr_o), 32'd0);
    check("rst data", 32'(data_o), 32'd0);
    check("rst poci", 32'(spi_poci_o), 32'd0);

    do_frame("wr_addr", 32'h405AE80F, 4, 0, 8'h00, 3);
    check("wr_addr ptr", 32'(dut.pointer), 32'h0E810);

    do_frame("rd_addr", 32'hC1234500, 3, 0, 8'hAB, 1);
    do_frame("rd_next1", 32'h80000000, 1, 0, 8'hCD, 0);
    do_frame("rd_next2", 32'h80000000, 1, 0, 8'h5E, 2);

    do_frame("wr_wrap", 32'h4111FFFF, 4, 0, 8'h00, 0);
    do_frame("wr_next", 32'h00220000, 2, 0, 8'h00, 0);
    check("wrap addr", 32'(dut.pointer), 32'h00001);

    do_frame("abort", 32'hC0120000, 2, 4, 8'h00, 0);
    do_frame("after_abort", 32'h80000000, 1, 0, 8'h77, 0);

    for (int it = 0; it < 16; it++) begin
      rnd   = $urandom;
      fill  = $urandom;
      raddr = 17'($urandom);
      kind  = $urandom_range(0, 3);
      case (kind)
        0:       fill = {2'b01, rnd[5:1], raddr[16], fill[23:16], raddr[15:0]};
        1:       fill = {2'b11, rnd[5:1], raddr[16], raddr[15:0], fill[7:0]};
        2:       fill = {2'b10, rnd[5:0], fill[23:0]};
        default: fill = {2'b00, rnd[5:0], fill[23:0]};
      endcase
      need_r = (kind == 0) ? 4 : (kind == 1) ? 3 : (kind == 2) ? 1 : 2;
      nb     = need_r + $urandom_range(0, 4 - need_r);
      extra  = 0;
      if (need_r >= 2 && $urandom_range(0, 4) == 0) begin
        nb    = need_r - 1;
        extra = $urandom_range(1, 7);
      end
      do_frame("rand", fill, nb, extra, 8'($urandom), $urandom_range(0, 3));
    end

    resp_en = 0;
    do_frame("ovr_rd", 32'h80000000, 1, 0, 8'h00, 0);
    do_frame("ovr_again", 32'h80000000, 1, 0, 8'h00, 0);
    check("ovr valid held", 32'(valid_o), 32'd1);

    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i   = 1'b0;
    m_ptr     = '0;
    m_rd_buf  = '0;
    m_pend    = 0;
    m_overrun = 0;
    check("post_rst valid", 32'(valid_o), 32'd0);
    check("post_rst poci", 32'(spi_poci_o), 32'd0);
    check("post_rst overrun", 32'(dut.overrun), 32'(m_overrun));
    repeat (4) @(negedge clk);
    resp_en = 1;
    do_frame("post_rst", 32'h80000000, 1, 0, 8'h3C, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
